door_ctrl: RTL and testbench

DOOR_CTRL -- requirements
Module: door_ctrl

---
 rtl/door_ctrl.sv | 167 ++++++++++++++++
 tb/tb_door_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/door_ctrl.sv
// Garage door controller: edge-detected requests drive a motor FSM with
// obstruction reversal, travel timeout watchdog and optional auto-close.
module door_ctrl #(
  parameter int DEAD_CYC   = 4,
  parameter int TRAVEL_MAX = 64,
  parameter int AUTOCLOSE  = 32,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       rmt,
  input  logic       obstruct,
  input  logic       up_limit,
  input  logic       dn_limit,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    OPEN    = 3'd1,
    CLOSED  = 3'd2,
    OPENING = 3'd3,
    CLOSING = 3'd4,
    STOPPED = 3'd5,
    DEAD    = 3'd6,
    FAULT   = 3'd7
  } state_t;

  localparam logic [CW:0] TRAVEL_LIM = (CW+1)'(TRAVEL_MAX);
  localparam logic [CW:0] AC_LIM     = (CW+1)'(AUTOCLOSE);
  localparam logic [CW:0] DEAD_LIM   = (CW+1)'(DEAD_CYC);

  state_t        state;
  state_t        state_n;
  logic          btn_q;
  logic          rmt_q;
  logic          act;
  logic          dir_up;
  logic          dir_up_n;
  logic          ac_clr;
  logic [CW-1:0] tr_cnt;
  logic [CW-1:0] ac_cnt;
  logic [CW-1:0] dd_cnt;
  logic [CW:0]   tr_inc;
  logic [CW:0]   ac_inc;
  logic [CW:0]   dd_inc;
  logic          travel_to;
  logic          autoclose_to;
  logic          dead_done;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Timeouts look one count ahead so the transition lands on the Nth cycle.
  assign act          = (btn & ~btn_q) | (rmt & ~rmt_q);
  assign tr_inc       = {1'b0, tr_cnt} + (CW+1)'(1);
  assign ac_inc       = {1'b0, ac_cnt} + (CW+1)'(1);
  assign dd_inc       = {1'b0, dd_cnt} + (CW+1)'(1);
  assign travel_to    = (tr_inc >= TRAVEL_LIM);
  assign autoclose_to = (AUTOCLOSE != 0) && (ac_inc >= AC_LIM);
  assign dead_done    = (dd_inc >= DEAD_LIM);
  assign state_o      = state;

  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    ac_clr   = 1'b0;
    if (state != FAULT && up_limit && dn_limit) begin
      state_n = FAULT;
    end else begin
      case (state)
        INIT: begin
          if (up_limit)      state_n = OPEN;
          else if (dn_limit) state_n = CLOSED;
          else begin
            state_n  = STOPPED;
            dir_up_n = 1'b1;
          end
        end
        OPEN: begin
          if (obstruct)                  ac_clr  = 1'b1;
          else if (act || autoclose_to)  state_n = CLOSING;
        end
        CLOSED: begin
          if (act) state_n = OPENING;
        end
        OPENING: begin
          if (up_limit) state_n = OPEN;
          else if (act) begin
            state_n  = STOPPED;
            dir_up_n = 1'b0;
          end else if (travel_to) state_n = FAULT;
        end
        CLOSING: begin
          if (dn_limit)      state_n = CLOSED;
          else if (obstruct) state_n = DEAD;
          else if (act) begin
            state_n  = STOPPED;
            dir_up_n = 1'b1;
          end else if (travel_to) state_n = FAULT;
        end
        STOPPED: begin
          if (act) begin
            if (dir_up)         state_n = OPENING;
            else if (!obstruct) state_n = CLOSING;
          end
        end
        DEAD: begin
          if (dead_done) state_n = OPENING;
        end
        FAULT:   state_n = FAULT;
        default: state_n = INIT;
      endcase
    end
  end

  // Motor drives come from the next state so they switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      btn_q    <= 1'b0;
      rmt_q    <= 1'b0;
      dir_up   <= 1'b1;
      motor_up <= 1'b0;
      motor_dn <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      btn_q    <= btn;
      rmt_q    <= rmt;
      dir_up   <= dir_up_n;
      motor_up <= (state_n == OPENING);
      motor_dn <= (state_n == CLOSING);
      fault    <= fault | (state_n == FAULT);
    end
  end

  // Every counter restarts on any state change and saturates while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_cnt <= '0;
      ac_cnt <= '0;
      dd_cnt <= '0;
    end else begin
      if (state_n != state)
        tr_cnt <= '0;
      else if (state == OPENING || state == CLOSING)
        tr_cnt <= sat_inc(tr_cnt);

      if (state_n != state || ac_clr)
        ac_cnt <= '0;
      else if (state == OPEN)
        ac_cnt <= sat_inc(ac_cnt);

      if (state_n != state)
        dd_cnt <= '0;
      else if (state == DEAD)
        dd_cnt <= sat_inc(dd_cnt);
    end
  end

endmodule

// File: tb/tb_door_ctrl.sv
// Directed bench for door_ctrl; expected vectors are {fault, motor_up,
// motor_dn, state_o} written out by hand for each step.
module tb_door_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       rmt;
  logic       obstruct;
  logic       up_limit;
  logic       dn_limit;
  logic       motor_up;
  logic       motor_dn;
  logic       fault;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  logic monitor_on = 1'b0;

  door_ctrl #(
    .DEAD_CYC(4),
    .TRAVEL_MAX(64),
    .AUTOCLOSE(32),
    .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .rmt(rmt),
    .obstruct(obstruct),
    .up_limit(up_limit),
    .dn_limit(dn_limit),
    .motor_up(motor_up),
    .motor_dn(motor_dn),
    .fault(fault),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] expv(input logic [2:0] st, input logic mu, input logic md, input logic f);
    return {f, mu, md, st};
  endfunction

  function automatic logic [5:0] obs();
    return {fault, motor_up, motor_dn, state_o};
  endfunction

  task automatic applyStimulus(input logic b, input logic r, input logic o, input logic u, input logic d);
    btn      = b;
    rmt      = r;
    obstruct = o;
    up_limit = u;
    dn_limit = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Motor exclusivity is sampled on every falling edge outside reset.
  always @(negedge clk) begin
    if (monitor_on && !rst)
      checkOutput("motor_excl", {5'b0, motor_up & motor_dn}, 6'd0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    btn = 0; rmt = 0; obstruct = 0; up_limit = 1; dn_limit = 0; rst = 1;
    #12;
    checkOutput("reset", obs(), expv(3'd0, 0, 0, 0));
    rst = 0;
    monitor_on = 1'b1;

    // Basic open/close cycle
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("init_open", obs(), expv(3'd1, 0, 0, 0));
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("btn_closing", obs(), expv(3'd4, 0, 1, 0));
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("still_closing", obs(), expv(3'd4, 0, 1, 0));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("closed", obs(), expv(3'd2, 0, 0, 0));
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("rmt_opening", obs(), expv(3'd3, 1, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("opened", obs(), expv(3'd1, 0, 0, 0));

    // Auto-close after 32 idle cycles in OPEN
    idle(31);
    checkOutput("ac_31", obs(), expv(3'd1, 0, 0, 0));
    idle(1);
    checkOutput("ac_32", obs(), expv(3'd4, 0, 1, 0));

    // Obstruction while closing: 4 dead cycles then reopen
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("dead_entry", obs(), expv(3'd6, 0, 0, 0));
    idle(3);
    checkOutput("dead_3", obs(), expv(3'd6, 0, 0, 0));
    idle(1);
    checkOutput("dead_reopen", obs(), expv(3'd3, 1, 0, 0));
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("opening_obs_ign", obs(), expv(3'd3, 1, 0, 0));
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("opened2", obs(), expv(3'd1, 0, 0, 0));

    // Obstruct holds OPEN against auto-close and requests
    applyStimulus(0, 0, 1, 1, 0);
    idle(39);
    checkOutput("ac_obstructed", obs(), expv(3'd1, 0, 0, 0));
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("act_obstructed", obs(), expv(3'd1, 0, 0, 0));
    applyStimulus(0, 0, 0, 1, 0);

    // Stop/resume in both directions, then double-limit fault
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("closing3", obs(), expv(3'd4, 0, 1, 0));
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stop_mid_close", obs(), expv(3'd5, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("resume_up", obs(), expv(3'd3, 1, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stop_mid_open", obs(), expv(3'd5, 0, 0, 0));
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("stop_obs_hold", obs(), expv(3'd5, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("resume_down", obs(), expv(3'd4, 0, 1, 0));
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("both_limits", obs(), expv(3'd7, 0, 0, 1));
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("fault_sticky", obs(), expv(3'd7, 0, 0, 1));

    // Travel timeout while closing
    rst = 1;
    #1;
    checkOutput("reset2", obs(), expv(3'd0, 0, 0, 0));
    up_limit = 1; dn_limit = 0; rmt = 0;
    rst = 0;
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("init_open2", obs(), expv(3'd1, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, 0);
    idle(63);
    checkOutput("travel_63", obs(), expv(3'd4, 0, 1, 0));
    idle(1);
    checkOutput("travel_fault", obs(), expv(3'd7, 0, 0, 1));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("fault_limit_ign", obs(), expv(3'd7, 0, 0, 1));

    // Async reset mid-OPENING, no clock edge needed
    rst = 1;
    #2;
    up_limit = 0; dn_limit = 0; btn = 0;
    rst = 0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("init_stopped", obs(), expv(3'd5, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stopped_up", obs(), expv(3'd3, 1, 0, 0));
    #2;
    rst = 1;
    #1;
    checkOutput("async_rst", obs(), expv(3'd0, 0, 0, 0));
    #2;
    rst = 0;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("init_closed", obs(), expv(3'd2, 0, 0, 0));

    monitor_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
